sargantana_icache_mem_ctrl: RTL and testbench
=============================================

Name: sargantana_icache_mem_ctrl

Overview:
Sequencer and arbiter in front of the icache tag/data memory macro. It shares the single memory port between three requesters: fetch lookups, refill writes from the miss unit, and whole-cache flushes. It also runs an automatic tag-invalidation sweep after reset, because tag SRAM contents are not reset. All memory-side outputs are driven combinationally from the FSM state and the granted request. The memory registers them, giving a 1-cycle read latency.

Parameters:
ICACHE_N_WAY, 4, number of ways; width of the per-way request vectors.
TAG_DEPTH, 64, number of sets; must equal 2**ADDR_WIDHT.
SET_WIDHT, 256, cache line width in bits.
TAG_WIDHT, 20, tag width in bits.
ADDR_WIDHT, 6, set index width.

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; asynchronous, active-low
lookup_valid_i  in  1  fetch read request
lookup_idx_i  in  ADDR_WIDHT  set index to read
lookup_ready_o  out  1  lookup granted this cycle
rd_valid_o  out  1  tag/line/valid data on the memory outputs is valid (1 cycle after grant)
refill_valid_i  in  1  refill write request
refill_way_i  in  ICACHE_N_WAY  one-hot victim way
refill_idx_i  in  ADDR_WIDHT  set index to write
refill_tag_i  in  TAG_WIDHT  tag to write
refill_line_i  in  SET_WIDHT  line to write
refill_ready_o  out  1  refill granted this cycle
flush_req_i  in  1  single-cycle flush request pulse
flush_busy_o  out  1  sweep (init or flush) in progress or pending
flush_done_o  out  1  1-cycle pulse after the last set is invalidated
tag_req_o  out  ICACHE_N_WAY  tag memory per-way request
data_req_o  out  ICACHE_N_WAY  data memory per-way request
tag_we_o  out  1  tag write enable
data_we_o  out  1  data write enable
flush_en_o  out  1  flush indication to the tag memory
valid_bit_o  out  1  valid bit to write
tag_o  out  TAG_WIDHT  tag write data
cline_o  out  SET_WIDHT  line write data
addr_o  out  ADDR_WIDHT  set index

Behaviour:
- FSM states:
  - RST_WAIT: reset state; all memory outputs zero.
  - SWEEP: invalidation walk.
  - IDLE: serve refill and lookup traffic.
- Reset values: state=RST_WAIT, sweep counter=0, flush_pend=0, rd_valid_o=0, flush_done_o=0. Every req/we/flush_en output is 0 while in RST_WAIT.
- RST_WAIT -> SWEEP unconditionally on the first clock after reset release.
- SWEEP, per cycle:
  - tag_req_o all-ones, tag_we_o=1, valid_bit_o=0, flush_en_o=1, addr_o=counter.
  - data_req_o=0, data_we_o=0.
  - Counter increments each cycle.
  - When counter==TAG_DEPTH-1: wrap counter to 0, go to IDLE, pulse flush_done_o on the following cycle.
  - A sweep takes exactly TAG_DEPTH cycles.
- Both ready outputs are 0 whenever the state is not IDLE. flush_busy_o=1 in RST_WAIT, in SWEEP, or when flush_pend=1.
- IDLE priority, fixed: pending flush > refill > lookup.
  - Pending flush: go to SWEEP next cycle; no grants this cycle.
  - Refill grant: refill_ready_o=1; tag_req_o=data_req_o=refill_way_i; tag_we_o=data_we_o=1; valid_bit_o=1; tag_o/cline_o/addr_o driven from the refill inputs.
  - Lookup grant: only if no refill. lookup_ready_o=1; tag_req_o=data_req_o all-ones; both we=0; addr_o=lookup_idx_i.
- rd_valid_o is registered: it equals the previous cycle's lookup grant.
- flush_req_i:
  - In IDLE: sets flush_pend; the sweep starts the cycle after.
  - Simultaneous with a refill/lookup: that request is still granted in the same cycle.
  - Arriving during SWEEP or RST_WAIT: ignored; no re-queue; no extra flush_done_o.
- flush_pend clears on entry to SWEEP.
- Reset asserted mid-sweep: async return to RST_WAIT; the full sweep restarts from set 0.
- A refill_way_i that is not one-hot is passed through unchanged; checking it is the miss unit's responsibility. An SVA assertion flags it.
- Requesters must hold valid and payload stable until ready (valid/ready handshake).

Decomposition:
- Package sargantana_icache_pkg:
  - FSM state enum (RST_WAIT, SWEEP, IDLE).
  - Default geometry constants.
  - Refill request struct {way, idx, tag, line}.
- One sub-module: sargantana_icache_sweep_cnt, the set counter with wrap and last-set flag.

Test Plan:
- Release reset, no requests -> 64 cycles of tag_we_o=1/valid_bit_o=0 with addr_o 0..63; flush_done_o pulses once; lookup_ready_o=0 throughout the sweep.
- IDLE, lookup idx=5 -> addr_o=5, tag_req_o=4'b1111, lookup_ready_o=1; rd_valid_o=1 exactly one cycle later.
- Refill (way=4'b0100, idx=9, tag=20'hABCDE) and lookup in the same cycle -> refill granted with tag_req_o=data_req_o=4'b0100 and valid_bit_o=1; lookup stalls one cycle, then is granted.
- flush_req_i pulse concurrent with a refill -> refill granted that cycle; the next cycle enters SWEEP for 64 cycles; flush_done_o pulses once.
- flush_req_i at sweep cycle 10 -> ignored; only one flush_done_o pulse.
- Assert rstn_i at sweep addr_o=30 -> outputs zero immediately; after release the sweep restarts at addr_o=0.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the icache memory controller slice.
package sargantana_icache_pkg;

    localparam int DEF_ICACHE_N_WAY = 4;
    localparam int DEF_TAG_DEPTH    = 64;
    localparam int DEF_SET_WIDHT    = 256;
    localparam int DEF_TAG_WIDHT    = 20;
    localparam int DEF_ADDR_WIDHT   = 6;

    typedef enum logic [1:0] {
        RST_WAIT,
        SWEEP,
        IDLE
    } ctrl_state_t;

    typedef struct packed {
        logic [DEF_ICACHE_N_WAY-1:0] way;
        logic [DEF_ADDR_WIDHT-1:0]   idx;
        logic [DEF_TAG_WIDHT-1:0]    tag;
        logic [DEF_SET_WIDHT-1:0]    line;
    } refill_req_t;

endpackage

// File: rtl/sargantana_icache_sweep_cnt.sv
// Set counter for the tag invalidation walk; wraps to 0 after the last set.
module sargantana_icache_sweep_cnt #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [AW-1:0] idx,
    output logic          last
);

    assign last = (idx == AW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (en) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/sargantana_icache_mem_ctrl.sv
// Arbiter/sequencer sharing the icache tag/data memory port between
// lookups, refills and invalidation sweeps (post-reset and flush).
module sargantana_icache_mem_ctrl
    import sargantana_icache_pkg::*;
#(
    parameter int ICACHE_N_WAY = DEF_ICACHE_N_WAY,
    parameter int TAG_DEPTH    = DEF_TAG_DEPTH,
    parameter int SET_WIDHT    = DEF_SET_WIDHT,
    parameter int TAG_WIDHT    = DEF_TAG_WIDHT,
    parameter int ADDR_WIDHT   = DEF_ADDR_WIDHT
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    lookup_valid_i,
    input  logic [ADDR_WIDHT-1:0]   lookup_idx_i,
    output logic                    lookup_ready_o,
    output logic                    rd_valid_o,
    input  logic                    refill_valid_i,
    input  logic [ICACHE_N_WAY-1:0] refill_way_i,
    input  logic [ADDR_WIDHT-1:0]   refill_idx_i,
    input  logic [TAG_WIDHT-1:0]    refill_tag_i,
    input  logic [SET_WIDHT-1:0]    refill_line_i,
    output logic                    refill_ready_o,
    input  logic                    flush_req_i,
    output logic                    flush_busy_o,
    output logic                    flush_done_o,
    output logic [ICACHE_N_WAY-1:0] tag_req_o,
    output logic [ICACHE_N_WAY-1:0] data_req_o,
    output logic                    tag_we_o,
    output logic                    data_we_o,
    output logic                    flush_en_o,
    output logic                    valid_bit_o,
    output logic [TAG_WIDHT-1:0]    tag_o,
    output logic [SET_WIDHT-1:0]    cline_o,
    output logic [ADDR_WIDHT-1:0]   addr_o
);

    ctrl_state_t            state;
    logic                   flush_pend;
    logic                   sweep_en;
    logic                   sweep_last;
    logic [ADDR_WIDHT-1:0]  sweep_idx;
    refill_req_t            refill_req;

    assign refill_req = '{way: refill_way_i, idx: refill_idx_i,
                          tag: refill_tag_i, line: refill_line_i};
    assign sweep_en   = (state == SWEEP);

    sargantana_icache_sweep_cnt #(
        .DEPTH (TAG_DEPTH),
        .AW    (ADDR_WIDHT)
    ) sweep_cnt (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .en    (sweep_en),
        .idx   (sweep_idx),
        .last  (sweep_last)
    );

    // A pending flush blocks all grants for one cycle while the FSM moves to SWEEP.
    always_comb begin
        lookup_ready_o = 1'b0;
        refill_ready_o = 1'b0;
        tag_req_o      = '0;
        data_req_o     = '0;
        tag_we_o       = 1'b0;
        data_we_o      = 1'b0;
        flush_en_o     = 1'b0;
        valid_bit_o    = 1'b0;
        tag_o          = '0;
        cline_o        = '0;
        addr_o         = '0;
        case (state)
            SWEEP: begin
                tag_req_o  = '1;
                tag_we_o   = 1'b1;
                flush_en_o = 1'b1;
                addr_o     = sweep_idx;
            end
            IDLE: begin
                if (!flush_pend) begin
                    if (refill_valid_i) begin
                        refill_ready_o = 1'b1;
                        tag_req_o      = refill_req.way;
                        data_req_o     = refill_req.way;
                        tag_we_o       = 1'b1;
                        data_we_o      = 1'b1;
                        valid_bit_o    = 1'b1;
                        tag_o          = refill_req.tag;
                        cline_o        = refill_req.line;
                        addr_o         = refill_req.idx;
                    end else if (lookup_valid_i) begin
                        lookup_ready_o = 1'b1;
                        tag_req_o      = '1;
                        data_req_o     = '1;
                        addr_o         = lookup_idx_i;
                    end
                end
            end
            default: ;
        endcase
    end

    assign flush_busy_o = (state != IDLE) || flush_pend;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= RST_WAIT;
            flush_pend   <= 1'b0;
            rd_valid_o   <= 1'b0;
            flush_done_o <= 1'b0;
        end else begin
            rd_valid_o   <= lookup_ready_o;
            flush_done_o <= (state == SWEEP) && sweep_last;
            case (state)
                RST_WAIT: state <= SWEEP;
                SWEEP: begin
                    if (sweep_last) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (flush_pend) begin
                        state      <= SWEEP;
                        flush_pend <= 1'b0;
                    end else if (flush_req_i) begin
                        flush_pend <= 1'b1;
                    end
                end
                default: state <= RST_WAIT;
            endcase
        end
    end

    // The victim way must be one-hot; it is forwarded as-is regardless.
    refill_way_onehot: assert property (
        @(posedge clk_i) disable iff (!rstn_i)
        refill_valid_i |-> $onehot(refill_way_i)
    );

endmodule

// File: tb/tb_sargantana_icache_mem_ctrl.sv
// Scoreboard bench: stimulus queues expected memory accesses, a negedge monitor pops and checks them.
module tb_sargantana_icache_mem_ctrl;

    logic         clk_i;
    logic         rstn_i;
    logic         lookup_valid_i;
    logic [5:0]   lookup_idx_i;
    logic         lookup_ready_o;
    logic         rd_valid_o;
    logic         refill_valid_i;
    logic [3:0]   refill_way_i;
    logic [5:0]   refill_idx_i;
    logic [19:0]  refill_tag_i;
    logic [255:0] refill_line_i;
    logic         refill_ready_o;
    logic         flush_req_i;
    logic         flush_busy_o;
    logic         flush_done_o;
    logic [3:0]   tag_req_o;
    logic [3:0]   data_req_o;
    logic         tag_we_o;
    logic         data_we_o;
    logic         flush_en_o;
    logic         valid_bit_o;
    logic [19:0]  tag_o;
    logic [255:0] cline_o;
    logic [5:0]   addr_o;

    typedef struct {
        logic [3:0]   req;
        logic [3:0]   dreq;
        logic         twe;
        logic         dwe;
        logic         flush;
        logic         vbit;
        logic [5:0]   addr;
        logic [19:0]  tag;
        logic [255:0] line;
        logic         lk;
        logic         rf;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    bit   exp_rd;
    bit   exp_done;
    int   n_tests;
    int   n_fail;

    sargantana_icache_mem_ctrl dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_idx_i   (lookup_idx_i),
        .lookup_ready_o (lookup_ready_o),
        .rd_valid_o     (rd_valid_o),
        .refill_valid_i (refill_valid_i),
        .refill_way_i   (refill_way_i),
        .refill_idx_i   (refill_idx_i),
        .refill_tag_i   (refill_tag_i),
        .refill_line_i  (refill_line_i),
        .refill_ready_o (refill_ready_o),
        .flush_req_i    (flush_req_i),
        .flush_busy_o   (flush_busy_o),
        .flush_done_o   (flush_done_o),
        .tag_req_o      (tag_req_o),
        .data_req_o     (data_req_o),
        .tag_we_o       (tag_we_o),
        .data_we_o      (data_we_o),
        .flush_en_o     (flush_en_o),
        .valid_bit_o    (valid_bit_o),
        .tag_o          (tag_o),
        .cline_o        (cline_o),
        .addr_o         (addr_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_sweep();
        for (int a = 0; a < 64; a++) begin
            exp_q.push_back('{req: 4'hF, dreq: 4'h0, twe: 1'b1, dwe: 1'b0, flush: 1'b1, vbit: 1'b0,
                              addr: 6'(a), tag: '0, line: '0, lk: 1'b0, rf: 1'b0});
        end
    endfunction

    // Monitor: every DUT memory access must match the head of the expected queue.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            exp_rd   = 1'b0;
            exp_done = 1'b0;
        end else begin
            check_output("rd_valid", rd_valid_o, exp_rd);
            check_output("flush_done", flush_done_o, exp_done);
            exp_rd   = 1'b0;
            exp_done = 1'b0;
            if (tag_req_o != 4'h0) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_access", tag_req_o, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check_output("access_ctrl",
                        {tag_req_o, data_req_o, tag_we_o, data_we_o, flush_en_o, lookup_ready_o, refill_ready_o},
                        {cur.req, cur.dreq, cur.twe, cur.dwe, cur.flush, cur.lk, cur.rf});
                    check_output("access_addr", addr_o, cur.addr);
                    if (!cur.lk) check_output("valid_bit", valid_bit_o, cur.vbit);
                    if (cur.rf) begin
                        check_output("refill_tag", tag_o, cur.tag);
                        check_output("refill_line", cline_o, cur.line);
                    end
                    exp_rd   = cur.lk;
                    exp_done = cur.flush && (cur.addr == 6'd63);
                end
            end else begin
                check_output("no_access_ctrl",
                    {lookup_ready_o, refill_ready_o, data_req_o, tag_we_o, data_we_o, flush_en_o}, 0);
            end
        end
    end

    // Issue refill/lookup/flush together, queue their expected accesses, and hold each until granted.
    task automatic apply_stimulus(input bit do_rf, input logic [3:0] way, input logic [5:0] ridx,
                                  input logic [19:0] tag, input logic [255:0] line,
                                  input bit do_lk, input logic [5:0] lidx, input bit do_fl, input int budget);
        bit rf_pend, lk_pend, rf_g, lk_g;
        int n;
        if (do_rf)
            exp_q.push_back('{req: way, dreq: way, twe: 1'b1, dwe: 1'b1, flush: 1'b0, vbit: 1'b1,
                              addr: ridx, tag: tag, line: line, lk: 1'b0, rf: 1'b1});
        if (do_fl) push_sweep();
        if (do_lk)
            exp_q.push_back('{req: 4'hF, dreq: 4'hF, twe: 1'b0, dwe: 1'b0, flush: 1'b0, vbit: 1'b0,
                              addr: lidx, tag: '0, line: '0, lk: 1'b1, rf: 1'b0});
        @(posedge clk_i);
        #1;
        refill_valid_i = do_rf;
        refill_way_i   = do_rf ? way : 4'h0;
        refill_idx_i   = ridx;
        refill_tag_i   = tag;
        refill_line_i  = line;
        lookup_valid_i = do_lk;
        lookup_idx_i   = lidx;
        flush_req_i    = do_fl;
        rf_pend = do_rf;
        lk_pend = do_lk;
        n = 0;
        do begin
            @(negedge clk_i);
            rf_g = rf_pend && refill_ready_o;
            lk_g = lk_pend && lookup_ready_o;
            @(posedge clk_i);
            #1;
            flush_req_i = 1'b0;
            if (rf_g) begin
                rf_pend        = 1'b0;
                refill_valid_i = 1'b0;
                refill_way_i   = 4'h0;
            end
            if (lk_g) begin
                lk_pend        = 1'b0;
                lookup_valid_i = 1'b0;
            end
            n++;
        end while ((rf_pend || lk_pend) && n < budget);
        check_output("handshake_done", {rf_pend, lk_pend}, 0);
        refill_valid_i = 1'b0;
        lookup_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge clk_i);
            idle = !flush_busy_o;
        end
        check_output("reach_idle", idle, 1);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_mem", {tag_req_o, data_req_o, tag_we_o, data_we_o, flush_en_o}, 0);
        check_output("rst_ready", {lookup_ready_o, refill_ready_o}, 0);
        check_output("rst_status", {rd_valid_o, flush_done_o, flush_busy_o}, 3'b001);
    endtask

    initial begin
        bit found;
        n_tests = 0;
        n_fail  = 0;
        exp_rd = 1'b0;
        exp_done = 1'b0;
        rstn_i = 1'b1;
        lookup_valid_i = 1'b0;
        lookup_idx_i = '0;
        refill_valid_i = 1'b0;
        refill_way_i = '0;
        refill_idx_i = '0;
        refill_tag_i = '0;
        refill_line_i = '0;
        flush_req_i = 1'b0;
        #1 rstn_i = 1'b0;
        #2 check_reset_outputs();
        push_sweep();
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Lookup held through the whole power-up sweep; granted only afterwards.
        apply_stimulus(0, 4'h0, 6'd0, 20'h0, '0, 1, 6'd7, 0, 100);
        apply_stimulus(0, 4'h0, 6'd0, 20'h0, '0, 1, 6'd5, 0, 4);
        apply_stimulus(1, 4'b0100, 6'd9, 20'hABCDE, {8{32'hDEADBEEF}}, 1, 6'd12, 0, 4);

        // Flush alongside a refill, then a stray flush pulse mid-sweep.
        apply_stimulus(1, 4'b0010, 6'd33, 20'h12345, {8{32'h0F1E2D3C}}, 0, 6'd0, 1, 4);
        repeat (11) @(posedge clk_i);
        #1 flush_req_i = 1'b1;
        @(posedge clk_i);
        #1 flush_req_i = 1'b0;
        wait_idle(200);
        apply_stimulus(1, 4'b1000, 6'd63, 20'hFFFFF, {8{32'hA5A5_5A5A}}, 0, 6'd0, 0, 4);
        apply_stimulus(0, 4'h0, 6'd0, 20'h0, '0, 1, 6'd63, 0, 4);

        // Reset in the middle of a flush sweep restarts the walk from set 0.
        apply_stimulus(0, 4'h0, 6'd0, 20'h0, '0, 0, 6'd0, 1, 1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_i);
            #1;
            found = tag_we_o && flush_en_o && (addr_o == 6'd30);
        end
        check_output("sweep_reach_30", found, 1);
        rstn_i = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        push_sweep();
        #5 rstn_i = 1'b1;
        wait_idle(200);
        apply_stimulus(0, 4'h0, 6'd0, 20'h0, '0, 1, 6'd0, 0, 4);

        repeat (4) @(posedge clk_i);
        check_output("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
